// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - restores natural bin order of a bit-reversed FFT output frame
module fft_reorder #(
    parameter int WIDTH = 12,
    parameter int N     = 256,
    parameter int LOG2N = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic [LOG2N-1:0] do_idx,
    output logic             do_last
);

    typedef enum logic {IDLE, READ} state_t;

    state_t           state, state_nx;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt, rd_cnt_nx;
    logic             wr_bank;
    logic             frame_end;
    logic             rd_fire;

    // Two banks packed into one array; the MSB of the address is the bank.
    logic [2*WIDTH-1:0] mem [0:2*N-1];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

    assign frame_end = di_en && (wr_cnt == LOG2N'(N - 1));
    assign rd_fire   = (state == READ);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (di_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (frame_end) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (di_en) begin
            mem[{wr_bank, bitrev(wr_cnt)}] <= {di_re, di_im};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rd_cnt <= '0;
        end else begin
            state  <= state_nx;
            rd_cnt <= rd_cnt_nx;
        end
    end

    // A frame end coinciding with the last read restarts the reader on the
    // freshly filled bank so back-to-back frames stream without a gap.
    always_comb begin
        state_nx  = state;
        rd_cnt_nx = rd_cnt;
        case (state)
            IDLE: begin
                if (frame_end) begin
                    state_nx  = READ;
                    rd_cnt_nx = '0;
                end
            end
            READ: begin
                rd_cnt_nx = rd_cnt + 1'b1;
                if (rd_cnt == LOG2N'(N - 1)) begin
                    state_nx = IDLE;
                end
                if (frame_end) begin
                    state_nx  = READ;
                    rd_cnt_nx = '0;
                end
            end
            default: begin
                state_nx  = IDLE;
                rd_cnt_nx = '0;
            end
        endcase
    end

    // The reader always uses the bank opposite the writer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            do_en   <= 1'b0;
            do_last <= 1'b0;
            do_re   <= '0;
            do_im   <= '0;
            do_idx  <= '0;
        end else begin
            do_en   <= rd_fire;
            do_last <= rd_fire && (rd_cnt == LOG2N'(N - 1));
            if (rd_fire) begin
                {do_re, do_im} <= mem[{~wr_bank, rd_cnt}];
                do_idx         <= rd_cnt;
            end
        end
    end

endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - randomized model-checked bench for fft_reorder (N=256 and N=16)
module tb_fft_reorder;

    typedef struct packed {
        int          due;
        logic [11:0] re;
        logic [11:0] im;
        int          idx;
        logic        last;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        den [2];
    logic [11:0] dre [2];
    logic [11:0] dim [2];
    logic        oen [2];
    logic        olast [2];
    logic [11:0] ore [2];
    logic [11:0] oim [2];
    logic [7:0]  oidx0;
    logic [3:0]  oidx1;

    int   total = 0;
    int   bad   = 0;
    int   cnt   = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [23:0] sbuf [2][256];
    int   wc [2];
    int   last_in [2];
    int   first_en [2];
    logic prev_en [2];
    int   run [2];
    int   maxrun [2];
    int   last_idx;
    logic [23:0] cap0 [256];
    logic [23:0] cap1 [16];

    always #5 clock = ~clock;

    fft_reorder #(.WIDTH(12), .N(256), .LOG2N(8)) dut0 (
        .clock(clock), .reset(reset),
        .di_en(den[0]), .di_re(dre[0]), .di_im(dim[0]),
        .do_en(oen[0]), .do_re(ore[0]), .do_im(oim[0]),
        .do_idx(oidx0), .do_last(olast[0])
    );

    fft_reorder #(.WIDTH(12), .N(16), .LOG2N(4)) dut1 (
        .clock(clock), .reset(reset),
        .di_en(den[1]), .di_re(dre[1]), .di_im(dim[1]),
        .do_en(oen[1]), .do_re(ore[1]), .do_im(oim[1]),
        .do_idx(oidx1), .do_last(olast[1])
    );

    function automatic int nn(input int m);
        return (m == 0) ? 256 : 16;
    endfunction

    function automatic int brev(input int v, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) begin
            r = r | (((v >> b) & 1) << (bits - 1 - b));
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, want, cnt);
        end
    endtask

    // Reference: natural bin i of a frame is the sample that arrived at position bitrev(i).
    initial begin : model
        exp_t e;
        wc[0] = 0;
        wc[1] = 0;
        forever begin
            @(posedge clock);
            cnt++;
            if (!reset) begin
                for (int m = 0; m < 2; m++) begin
                    if (den[m]) begin
                        sbuf[m][wc[m]] = {dre[m], dim[m]};
                        wc[m]++;
                        if (wc[m] == nn(m)) begin
                            wc[m]      = 0;
                            last_in[m] = cnt;
                            for (int i = 0; i < nn(m); i++) begin
                                e.due  = cnt + 1 + i;
                                {e.re, e.im} = sbuf[m][brev(i, (m == 0) ? 8 : 4)];
                                e.idx  = i;
                                e.last = (i == nn(m) - 1);
                                if (m == 0) q0.push_back(e);
                                else        q1.push_back(e);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : compare
        exp_t e;
        int   sz;
        int   idx;
        for (int m = 0; m < 2; m++) begin
            prev_en[m] = 1'b0;
            run[m]     = 0;
            maxrun[m]  = 0;
            first_en[m] = 0;
        end
        forever begin
            @(negedge clock);
            for (int m = 0; m < 2; m++) begin
                sz  = (m == 0) ? q0.size() : q1.size();
                idx = (m == 0) ? int'(oidx0) : int'(oidx1);
                if (sz > 0) e = (m == 0) ? q0[0] : q1[0];
                if (sz > 0 && e.due == cnt) begin
                    chk("do_en", int'(oen[m]), 1);
                    chk("do_re", int'(ore[m]), int'(e.re));
                    chk("do_im", int'(oim[m]), int'(e.im));
                    chk("do_idx", idx, e.idx);
                    chk("do_last", int'(olast[m]), int'(e.last));
                    if (m == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end else begin
                    chk("idle_en", int'(oen[m]), 0);
                    chk("idle_last", int'(olast[m]), 0);
                end
                if (oen[m]) begin
                    if (m == 0) cap0[oidx0] = {ore[0], oim[0]};
                    else        cap1[oidx1] = {ore[1], oim[1]};
                    if (olast[m] && m == 0) last_idx = idx;
                    if (!prev_en[m]) first_en[m] = cnt;
                    run[m]++;
                    if (run[m] > maxrun[m]) maxrun[m] = run[m];
                end else begin
                    run[m] = 0;
                end
                prev_en[m] = oen[m];
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int m, input int re, input int im);
        den[m] = 1'b1;
        dre[m] = 12'(re);
        dim[m] = 12'(im);
        step();
        den[m] = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 3000) begin
            step();
            k++;
        end
        step();
        chk("drain_pending", q0.size() + q1.size(), 0);
    endtask

    task automatic check_ramp_pins();
        chk("ramp_idx0", int'(cap0[0]), 24'h000_0FF);
        chk("ramp_idx1", int'(cap0[1]), 24'h080_07F);
        chk("ramp_idx2", int'(cap0[2]), 24'h040_0BF);
        chk("ramp_idx3", int'(cap0[3]), 24'h0C0_03F);
        chk("ramp_idx128", int'(cap0[128]), 24'h001_0FE);
        chk("ramp_idx255", int'(cap0[255]), 24'h0FF_000);
        chk("ramp_latency", first_en[0] - last_in[0], 1);
        chk("ramp_last_idx", last_idx, 255);
    endtask

    initial begin : stim
        int errs;
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            den[m] = 1'b0;
            dre[m] = '0;
            dim[m] = '0;
        end
        step();
        @(negedge clock);
        for (int m = 0; m < 2; m++) begin
            chk("rst_en", int'(oen[m]), 0);
            chk("rst_last", int'(olast[m]), 0);
            chk("rst_re", int'(ore[m]), 0);
            chk("rst_im", int'(oim[m]), 0);
        end
        chk("rst_idx0", int'(oidx0), 0);
        chk("rst_idx1", int'(oidx1), 0);
        step();
        reset = 1'b0;
        step();

        // Ramp, contiguous input
        last_idx = -1;
        for (int k = 0; k < 256; k++) send(0, k, 255 - k);
        drain();
        check_ramp_pins();

        // Ramp with 1,0,0 gap pattern
        last_idx = -1;
        for (int k = 0; k < 256; k++) begin
            send(0, k, 255 - k);
            step();
            step();
        end
        drain();
        check_ramp_pins();

        // Three back-to-back frames
        maxrun[0] = 0;
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 256; k++) send(0, k, f);
        drain();
        chk("b2b_contiguous", maxrun[0], 768);

        // Reset during frame-1 input while frame 0 is being read out
        for (int k = 0; k < 256; k++) send(0, $urandom_range(4095), $urandom_range(4095));
        for (int k = 0; k < 100; k++) send(0, k + 7, k + 9);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        wc[0] = 0;
        wc[1] = 0;
        @(negedge clock);
        chk("abort_en", int'(oen[0]), 0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step();
        for (int k = 0; k < 256; k++) send(0, $urandom_range(4095), $urandom_range(4095));
        drain();

        // Extreme values
        for (int k = 0; k < 256; k++) send(0, 12'h800, 12'h7FF);
        drain();
        errs = 0;
        for (int i = 0; i < 256; i++) if (cap0[i] != 24'h800_7FF) errs++;
        chk("extreme_all", errs, 0);

        // Random frames with random gaps
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 256; k++) begin
                send(0, $urandom_range(4095), $urandom_range(4095));
                if ($urandom_range(1) == 1) begin
                    for (int g = 0; g < int'($urandom_range(3)); g++) step();
                end
            end
        end
        drain();

        // N=16 instance: ramp then random back-to-back frames
        for (int k = 0; k < 16; k++) send(1, k, 0);
        drain();
        chk("n16_idx1", int'(cap1[1][23:12]), 8);
        chk("n16_idx5", int'(cap1[5][23:12]), 10);
        chk("n16_latency", first_en[1] - last_in[1], 1);
        maxrun[1] = 0;
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 16; k++) send(1, $urandom_range(4095), $urandom_range(4095));
        drain();
        chk("n16_contiguous", maxrun[1], 48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
